sha256_round_engine: RTL and testbench

- SHA-256 compression stage; directly consumes the majority term (computed internally as Maj(a,b,c) = (a&b)^(a&c)^(b&c)) together with Ch and the Σ0/Σ1 terms.
- Accepts one 512-bit message block as 16 streamed 32-bit words plus a 256-bit chaining value.
- Runs one round per clock and adds the chaining value back in.
- Presents the 256-bit digest through a valid/ready output; sits between the padding/block formatter and the multi-block hash controller.

---
 rtl/sha256_pkg.sv | 101 ++++++++++
 rtl/sha256_msg_schedule.sv | 44 ++++
 rtl/sha256_round_engine.sv | 162 ++++++++++++++++
 tb/tb_sha256_round_engine.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: round constants, IV, FSM states, working-register
// layout and the bitwise round helper functions.
package sha256_pkg;

   localparam int unsigned WORD_W   = 32;
   localparam int unsigned DIGEST_W = 256;
   localparam int unsigned NUM_K    = 64;
   localparam int unsigned T_W      = 6;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_EXPAND = 3'd2,
      ST_FINAL  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // Working registers a..h; a sits in the top word, matching H0 in hash_in.
   typedef struct packed {
      logic [WORD_W-1:0] a;
      logic [WORD_W-1:0] b;
      logic [WORD_W-1:0] c;
      logic [WORD_W-1:0] d;
      logic [WORD_W-1:0] e;
      logic [WORD_W-1:0] f;
      logic [WORD_W-1:0] g;
      logic [WORD_W-1:0] h;
   } work_t;

   localparam logic [WORD_W-1:0] K [NUM_K] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [DIGEST_W-1:0] SHA256_IV =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   function automatic logic [WORD_W-1:0] bsig0(input logic [WORD_W-1:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [WORD_W-1:0] bsig1(input logic [WORD_W-1:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [WORD_W-1:0] ssig0(input logic [WORD_W-1:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [WORD_W-1:0] ssig1(input logic [WORD_W-1:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] x, input logic [WORD_W-1:0] y,
                                            input logic [WORD_W-1:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] x, input logic [WORD_W-1:0] y,
                                             input logic [WORD_W-1:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   // One compression round applied to the working registers.
   function automatic work_t sha256_round(input work_t w, input logic [WORD_W-1:0] k,
                                          input logic [WORD_W-1:0] wt);
      logic [WORD_W-1:0] t1;
      logic [WORD_W-1:0] t2;
      work_t             r;
      t1  = w.h + bsig1(w.e) + ch(w.e, w.f, w.g) + k + wt;
      t2  = bsig0(w.a) + maj(w.a, w.b, w.c);
      r.a = t1 + t2;
      r.b = w.a;
      r.c = w.b;
      r.d = w.c;
      r.e = w.d + t1;
      r.f = w.e;
      r.g = w.f;
      r.h = w.g;
      return r;
   endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// Message schedule: 16-word circular buffer and the W[t] select between the
// streamed word (t < 16) and the expanded word (t >= 16).
module sha256_msg_schedule
   import sha256_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              i_we,
   input  logic [T_W-1:0]    i_t,
   input  logic [WORD_W-1:0] i_word,
   output logic [WORD_W-1:0] o_w_c
);

   logic [WORD_W-1:0] r_buf [16];
   logic [3:0]        w_slot;
   logic [3:0]        w_i2;
   logic [3:0]        w_i7;
   logic [3:0]        w_i15;
   logic [WORD_W-1:0] w_expand;

   // Buffer indices wrap naturally in 4 bits; slot t also holds W[t-16].
   always_comb begin
      w_slot = i_t[3:0];
      w_i2   = w_slot - 4'd2;
      w_i7   = w_slot - 4'd7;
      w_i15  = w_slot - 4'd15;
   end

   // Expanded word and W[t] select.
   always_comb begin
      w_expand = ssig1(r_buf[w_i2]) + r_buf[w_i7] + ssig0(r_buf[w_i15]) + r_buf[w_slot];
      o_w_c    = (i_t[5:4] == 2'b00) ? i_word : w_expand;
   end

   // Every executed round writes its W[t] back into slot t mod 16.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) r_buf[i] <= '0;
      end else if (i_we) begin
         r_buf[w_slot] <= o_w_c;
      end
   end

endmodule

// File: rtl/sha256_round_engine.sv
// SHA-256 compression engine: streams 16 message words, runs one round per
// clock, adds the chaining value back and offers the digest on valid/ready.
// Optional debug outputs dbg_round/dbg_a are built with SHA256_ROUND_DBG_EN.
module sha256_round_engine
   import sha256_pkg::*;
#(
   parameter int unsigned ROUNDS = 64
)(
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WORD_W-1:0]   in_word,
   input  logic [DIGEST_W-1:0] hash_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DIGEST_W-1:0] digest_out,
   output logic                busy
`ifdef SHA256_ROUND_DBG_EN
   ,output logic [T_W-1:0]     dbg_round
   ,output logic [WORD_W-1:0]  dbg_a
`endif
);

   localparam logic [T_W-1:0] LAST_ROUND = T_W'(ROUNDS - 1);

   state_t                r_state;
   state_t                w_next;
   logic [T_W-1:0]        r_t;
   work_t                 r_work;
   work_t                 w_work_in;
   work_t                 w_work_next;
   logic [DIGEST_W-1:0]   r_hash;
   logic [DIGEST_W-1:0]   r_digest;
   logic [DIGEST_W-1:0]   w_work_flat;
   logic [DIGEST_W-1:0]   w_digest_sum;
   logic                  r_in_ready;
   logic                  r_out_valid;
   logic                  r_busy;
   logic                  w_first;
   logic                  w_round_en;
   logic                  w_final;
   logic                  w_handshake;
   logic [WORD_W-1:0]     w_wt;

   sha256_msg_schedule u_sched (
      .clock  (clock),
      .reset  (reset),
      .i_we   (w_round_en),
      .i_t    (r_t),
      .i_word (in_word),
      .o_w_c  (w_wt)
   );

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Next-state and per-cycle control strobes.
   always_comb begin
      w_next      = r_state;
      w_first     = 1'b0;
      w_round_en  = 1'b0;
      w_final     = 1'b0;
      w_handshake = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (in_valid && r_in_ready) begin
               w_first    = 1'b1;
               w_round_en = 1'b1;
               w_next     = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (in_valid && r_in_ready) begin
               w_round_en = 1'b1;
               if (r_t == T_W'(15)) w_next = (ROUNDS == 16) ? ST_FINAL : ST_EXPAND;
            end
         end
         ST_EXPAND: begin
            w_round_en = 1'b1;
            if (r_t == LAST_ROUND) w_next = ST_FINAL;
         end
         ST_FINAL: begin
            w_final = 1'b1;
            w_next  = ST_DONE;
         end
         ST_DONE: begin
            if (r_out_valid && out_ready) begin
               w_handshake = 1'b1;
               w_next      = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Round datapath: block start seeds a..h from the chaining value.
   always_comb begin
      w_work_in   = w_first ? work_t'(hash_in) : r_work;
      w_work_next = sha256_round(w_work_in, K[r_t], w_wt);
      w_work_flat = r_work;
      w_digest_sum = '0;
      for (int i = 0; i < 8; i++) begin
         w_digest_sum[i*WORD_W +: WORD_W] = r_hash[i*WORD_W +: WORD_W] + w_work_flat[i*WORD_W +: WORD_W];
      end
   end

   // Working registers, chaining value, round counter and digest.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_t      <= '0;
         r_work   <= '0;
         r_hash   <= '0;
         r_digest <= '0;
      end else begin
         if (w_first)    r_hash <= hash_in;
         if (w_round_en) begin
            r_work <= w_work_next;
            r_t    <= r_t + T_W'(1);
         end
         if (w_final) begin
            r_digest <= w_digest_sum;
            r_t      <= '0;
         end
      end
   end

   // Registered handshake and status outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_in_ready  <= (w_next == ST_IDLE) || (w_next == ST_LOAD);
         r_out_valid <= (r_state == ST_DONE) && !w_handshake;
         r_busy      <= (w_next != ST_IDLE);
      end
   end

   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign digest_out = r_digest;
   assign busy       = r_busy;

`ifdef SHA256_ROUND_DBG_EN
   logic [T_W-1:0] r_dbg_round;

   // Index of the most recently executed round.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)          r_dbg_round <= '0;
      else if (w_round_en) r_dbg_round <= r_t;
   end

   assign dbg_round = r_dbg_round;
   assign dbg_a     = r_work.a;
`endif

endmodule

// File: tb/tb_sha256_round_engine.sv
// Self-checking bench for sha256_round_engine using an expected-digest queue.
module tb_sha256_round_engine;
   import sha256_pkg::*;

   logic         clock;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_word;
   logic [255:0] hash_in;
   logic         out_valid;
   logic         out_ready;
   logic [255:0] digest_out;
   logic         busy;
`ifdef SHA256_ROUND_DBG_EN
   logic [5:0]   dbg_round;
   logic [31:0]  dbg_a;
`endif

   int checks;
   int errors;
   logic [255:0] exp_q [$];
   logic [31:0]  blk [16];

   localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] D_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   sha256_round_engine dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_word    (in_word),
      .hash_in    (hash_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .digest_out (digest_out),
      .busy       (busy)
`ifdef SHA256_ROUND_DBG_EN
      ,.dbg_round (dbg_round)
      ,.dbg_a     (dbg_a)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic set_abc();
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
   endtask

   task automatic set_empty();
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[0] = 32'h80000000;
   endtask

   task automatic set_two_1();
      logic [31:0] m [14];
      m = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
            32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
            32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071};
      for (int i = 0; i < 14; i++) blk[i] = m[i];
      blk[14] = 32'h80000000;
      blk[15] = 32'h00000000;
   endtask

   task automatic set_two_2();
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[15] = 32'h000001c0;
   endtask

   // Streams blk[] into the engine; returns just after the edge accepting word 15.
   task automatic feed_block(input logic [255:0] h, input bit gaps, input bit toggle_h);
      int   i;
      int   guard;
      logic rdy;
      i = 0;
      guard = 0;
      hash_in = h;
      while (i < 16 && guard < 2000) begin
         guard++;
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            @(posedge clock);
            #1;
         end else begin
            in_valid = 1'b1;
            in_word  = blk[i];
            rdy      = in_ready;
            @(posedge clock);
            #1;
            if (rdy) begin
               i++;
               if (toggle_h) hash_in = ~hash_in ^ {8{$urandom}};
            end
         end
      end
      in_valid = 1'b0;
      if (i < 16) begin
         checks++;
         errors++;
         $display("FAIL feed_timeout words_accepted=%0d required 16", i);
      end
   endtask

   // Waits for out_valid, optionally stalls, then takes the digest.
   task automatic collect(input string name, input int stall, input bit cmp,
                          output int lat, output logic [255:0] got);
      logic [255:0] held;
      logic [255:0] exp;
      lat = 0;
      got = '0;
      while (out_valid !== 1'b1 && lat < 400) begin
         @(posedge clock);
         #1;
         lat++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s_valid_timeout out_valid=%b required 1", name, out_valid);
         out_ready = 1'b1;
         return;
      end
      held = digest_out;
      for (int k = 0; k < stall; k++) begin
         @(posedge clock);
         #1;
         checks++;
         if (digest_out !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_stall cyc=%0d digest=%h in_ready=%b out_valid=%b required digest=%h in_ready=0 out_valid=1",
                     name, k, digest_out, in_ready, out_valid, held);
         end
      end
      out_ready = 1'b1;
      got = digest_out;
      if (cmp) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_digest got=%h required <none queued>", name, digest_out);
         end else begin
            exp = exp_q.pop_front();
            if (digest_out !== exp) begin
               errors++;
               $display("FAIL %s_digest got=%h required %h", name, digest_out, exp);
            end
         end
      end
      @(posedge clock);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_release out_valid=%b in_ready=%b busy=%b required 0 1 0",
                  name, out_valid, in_ready, busy);
      end
   endtask

   task automatic check_zero_outputs(input string name);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || digest_out !== '0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s in_ready=%b out_valid=%b busy=%b digest=%h required all 0",
                  name, in_ready, out_valid, busy, digest_out);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_zero_outputs("reset_outputs");
      reset = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle in_ready=%b busy=%b out_valid=%b required 1 0 0",
                  in_ready, busy, out_valid);
      end
   endtask

   task automatic test_abc();
      int lat;
      logic [255:0] got;
      set_abc();
      exp_q.push_back(D_ABC);
      feed_block(SHA256_IV, 1'b0, 1'b0);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL abc_expand_status busy=%b in_ready=%b required 1 0", busy, in_ready);
      end
      collect("abc", 0, 1'b1, lat, got);
      checks++;
      if (lat != 50) begin
         errors++;
         $display("FAIL abc_latency edges=%0d required 50", lat);
      end
   endtask

   task automatic test_empty();
      int lat;
      logic [255:0] got;
      set_empty();
      exp_q.push_back(D_EMPTY);
      feed_block(SHA256_IV, 1'b0, 1'b0);
      collect("empty", 0, 1'b1, lat, got);
   endtask

   task automatic test_two_block();
      int lat;
      logic [255:0] mid;
      logic [255:0] got;
      set_two_1();
      feed_block(SHA256_IV, 1'b0, 1'b0);
      collect("two_blk1", 0, 1'b0, lat, mid);
      set_two_2();
      exp_q.push_back(D_TWO);
      feed_block(mid, 1'b0, 1'b0);
      collect("two_blk2", 0, 1'b1, lat, got);
   endtask

   task automatic test_backpressure();
      int lat;
      logic [255:0] got;
      set_abc();
      exp_q.push_back(D_ABC);
      out_ready = 1'b0;
      feed_block(SHA256_IV, 1'b1, 1'b0);
      collect("backpressure", 20, 1'b1, lat, got);
   endtask

   task automatic test_reset_mid();
      int lat;
      bit spurious;
      logic [255:0] got;
      set_abc();
      feed_block(SHA256_IV, 1'b0, 1'b0);
      repeat (14) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      check_zero_outputs("midreset_outputs");
      spurious = 1'b0;
      repeat (3) begin
         @(posedge clock);
         #1;
         if (out_valid !== 1'b0 || digest_out !== '0) spurious = 1'b1;
      end
      reset = 1'b1;
      repeat (80) begin
         @(posedge clock);
         #1;
         if (out_valid !== 1'b0) spurious = 1'b1;
      end
      checks++;
      if (spurious) begin
         errors++;
         $display("FAIL midreset_spurious out_valid/digest seen nonzero required 0");
      end
      exp_q.push_back(D_ABC);
      feed_block(SHA256_IV, 1'b0, 1'b0);
      collect("midreset_rerun", 0, 1'b1, lat, got);
   endtask

   task automatic test_hash_isolation();
      int lat;
      logic [255:0] got;
      set_abc();
      exp_q.push_back(D_ABC);
      feed_block(SHA256_IV, 1'b0, 1'b1);
      hash_in = ~SHA256_IV;
      collect("hash_iso", 0, 1'b1, lat, got);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      in_valid  = 1'b0;
      in_word   = '0;
      hash_in   = '0;
      out_ready = 1'b1;
      reset     = 1'b0;
      test_reset();
      test_abc();
      test_empty();
      test_two_block();
      test_backpressure();
      test_reset_mid();
      test_hash_isolation();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover entries=%0d required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
